// File: rtl/dispatch_stage_if.sv
// Bundles every dispatch_stage signal other than clk and rst:
//   rename side   : in_valid/in_ready and the per-lane renamed payload
//   regfile read  : rf_raddr (out of the stage) and rf_rdata (same-cycle data)
//   ALU writeback : wb_valid/wb_phys_rd/wb_data, one entry per bank
//   issue queue   : isq_full/isq_free_cnt, plus the isq_* dispatch payload
// The slave modport is the view dispatch_stage uses. The master modport is
// the view of whatever surrounds the stage (rename, regfile, ALUs, issue queue).
interface dispatch_stage_if #(
    parameter int PRW           = 6,
    parameter int ALU_W         = 4,
    parameter int OPT_W         = 2,
    parameter int ISQ_CNT_WIDTH = 4
);
    logic [1:0]                in_valid;
    logic                      in_ready;
    logic [1:0][ALU_W-1:0]     in_alu_cmd;
    logic [1:0][PRW-1:0]       in_phys_rs1;
    logic [1:0][OPT_W-1:0]     in_op2_type;
    logic [1:0][PRW-1:0]       in_phys_rs2;
    logic [1:0][31:0]          in_imm;
    logic [1:0]                in_rd_en;
    logic [1:0][PRW-1:0]       in_phys_rd;

    logic [1:0][PRW-1:0]       rf_raddr;
    logic [1:0][31:0]          rf_rdata;

    logic [1:0]                wb_valid;
    logic [1:0][PRW-1:0]       wb_phys_rd;
    logic [1:0][31:0]          wb_data;

    logic                      isq_full;
    logic [ISQ_CNT_WIDTH-1:0]  isq_free_cnt;
    logic [1:0]                isq_en;
    logic [1:0][ALU_W-1:0]     isq_alu_cmd;
    logic [1:0][PRW-1:0]       isq_op1;
    logic [1:0]                isq_op1_valid;
    logic [1:0][31:0]          isq_op2;
    logic [1:0]                isq_op2_valid;
    logic [1:0][OPT_W-1:0]     isq_op2_type;
    logic [1:0][PRW-1:0]       isq_phys_rd;

    modport master (
        output in_valid, in_alu_cmd, in_phys_rs1, in_op2_type, in_phys_rs2,
               in_imm, in_rd_en, in_phys_rd, rf_rdata, wb_valid, wb_phys_rd,
               wb_data, isq_full, isq_free_cnt,
        input  in_ready, rf_raddr, isq_en, isq_alu_cmd, isq_op1, isq_op1_valid,
               isq_op2, isq_op2_valid, isq_op2_type, isq_phys_rd
    );

    modport slave (
        input  in_valid, in_alu_cmd, in_phys_rs1, in_op2_type, in_phys_rs2,
               in_imm, in_rd_en, in_phys_rd, rf_rdata, wb_valid, wb_phys_rd,
               wb_data, isq_full, isq_free_cnt,
        output in_ready, rf_raddr, isq_en, isq_alu_cmd, isq_op1, isq_op1_valid,
               isq_op2, isq_op2_valid, isq_op2_type, isq_phys_rd
    );
endinterface

// File: rtl/dispatch_stage.sv
// dispatch_stage: front end of the issue-queue dispatch path.
// It accepts 2-wide renamed groups (lane0 is the older lane) and keeps a
// busy table of physical registers. For each operand it works out whether
// the value is ready, and it supplies op2 data. The group is held in one
// output register and presented to the issue queue as a whole. While a
// group waits for issue-queue space, the stage snoops ALU writeback so that
// no wakeup is lost.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset. It clears the busy table and drops
//        any group that is being held.
//   bus  dispatch_stage_if.slave, which carries the rename, regfile read,
//        writeback and issue-queue signals
module dispatch_stage #(
    parameter int              PHYS_REGS            = 64,
    parameter int              PHYS_REGS_ADDR_WIDTH = 6,
    parameter int              ISQ_CNT_WIDTH        = 4,
    parameter int              ALU_W                = 4,
    parameter int              OPT_W                = 2,
    parameter logic [OPT_W-1:0] OP_TYPE_REG         = '0
) (
    input  logic               clk,
    input  logic               rst,
    dispatch_stage_if.slave    bus
);
    localparam int DISPATCH_WIDTH = 2;
    localparam int PRW            = PHYS_REGS_ADDR_WIDTH;

    logic [PHYS_REGS-1:0]      busy_q, busy_d;
    logic [1:0]                out_v_q, out_v_d;
    logic [1:0][ALU_W-1:0]     alu_cmd_q, alu_cmd_d;
    logic [1:0][PRW-1:0]       op1_q, op1_d;
    logic [1:0]                op1_valid_q, op1_valid_d;
    logic [1:0][31:0]          op2_q, op2_d;
    logic [1:0]                op2_valid_q, op2_valid_d;
    logic [1:0][OPT_W-1:0]     op2_type_q, op2_type_d;
    logic [1:0][PRW-1:0]       phys_rd_q, phys_rd_d;

    logic                      fire;
    logic                      accept;
    logic [ISQ_CNT_WIDTH-1:0]  need_cnt;

    logic [1:0]                rs1_wb_hit, rs2_wb_hit, rs1_rdy, rs2_rdy;
    logic [1:0][31:0]          rs2_wb_data;
    logic [1:0][31:0]          cap_op2;
    logic [1:0]                cap_op2_valid;

    // The whole group goes out together or not at all. It therefore needs
    // room in the issue queue for every valid lane.
    assign need_cnt    = ISQ_CNT_WIDTH'(out_v_q[0]) + ISQ_CNT_WIDTH'(out_v_q[1]);
    assign fire        = (|out_v_q) && !bus.isq_full && (bus.isq_free_cnt >= need_cnt);
    assign bus.in_ready = !rst && (!(|out_v_q) || fire);
    assign accept      = (|bus.in_valid) && bus.in_ready;
    assign bus.rf_raddr = bus.in_phys_rs2;

    // Readiness of the incoming operands. A writeback in the same cycle
    // counts as ready. If two banks hit the same tag, bank 0's data wins.
    always_comb begin
        rs1_wb_hit    = '0;
        rs2_wb_hit    = '0;
        rs2_wb_data   = '0;
        rs1_rdy       = '0;
        rs2_rdy       = '0;
        cap_op2       = '0;
        cap_op2_valid = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            for (int b = DISPATCH_WIDTH - 1; b >= 0; b--) begin
                if (bus.wb_valid[b] && bus.wb_phys_rd[b] == bus.in_phys_rs1[i])
                    rs1_wb_hit[i] = 1'b1;
                if (bus.wb_valid[b] && bus.wb_phys_rd[b] == bus.in_phys_rs2[i]) begin
                    rs2_wb_hit[i]  = 1'b1;
                    rs2_wb_data[i] = bus.wb_data[b];
                end
            end
            rs1_rdy[i] = (bus.in_phys_rs1[i] == '0) || !busy_q[bus.in_phys_rs1[i]] || rs1_wb_hit[i];
            rs2_rdy[i] = (bus.in_phys_rs2[i] == '0) || !busy_q[bus.in_phys_rs2[i]] || rs2_wb_hit[i];
        end
        // If lane1 reads a register that lane0 writes, the operand is not
        // ready, even when a stale writeback to that tag is in flight.
        if (bus.in_valid[0] && bus.in_rd_en[0] && bus.in_phys_rd[0] != '0) begin
            if (bus.in_phys_rd[0] == bus.in_phys_rs1[1]) rs1_rdy[1] = 1'b0;
            if (bus.in_phys_rd[0] == bus.in_phys_rs2[1]) rs2_rdy[1] = 1'b0;
        end
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (bus.in_op2_type[i] != OP_TYPE_REG) begin
                cap_op2[i]       = bus.in_imm[i];
                cap_op2_valid[i] = 1'b1;
            end else if (rs2_rdy[i]) begin
                // p0 always reads zero from the regfile, so a writeback
                // tagged p0 must not override it.
                cap_op2[i]       = (rs2_wb_hit[i] && bus.in_phys_rs2[i] != '0) ?
                                   rs2_wb_data[i] : bus.rf_rdata[i];
                cap_op2_valid[i] = 1'b1;
            end else begin
                cap_op2[i]       = 32'(bus.in_phys_rs2[i]);
                cap_op2_valid[i] = 1'b0;
            end
        end
    end

    // Next-state logic for the output register. By default the held payload
    // absorbs wakeups from writeback. An accept overwrites the payload; a
    // fire with no accept empties the register.
    always_comb begin
        out_v_d     = out_v_q;
        alu_cmd_d   = alu_cmd_q;
        op1_d       = op1_q;
        op1_valid_d = op1_valid_q;
        op2_d       = op2_q;
        op2_valid_d = op2_valid_q;
        op2_type_d  = op2_type_q;
        phys_rd_d   = phys_rd_q;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            for (int b = DISPATCH_WIDTH - 1; b >= 0; b--) begin
                if (bus.wb_valid[b]) begin
                    if (!op1_valid_q[i] && bus.wb_phys_rd[b] == op1_q[i])
                        op1_valid_d[i] = 1'b1;
                    if (!op2_valid_q[i] && op2_type_q[i] == OP_TYPE_REG &&
                        bus.wb_phys_rd[b] == op2_q[i][PRW-1:0]) begin
                        op2_valid_d[i] = 1'b1;
                        op2_d[i]       = bus.wb_data[b];
                    end
                end
            end
        end
        if (accept) begin
            out_v_d     = bus.in_valid;
            alu_cmd_d   = bus.in_alu_cmd;
            op1_d       = bus.in_phys_rs1;
            op1_valid_d = rs1_rdy;
            op2_d       = cap_op2;
            op2_valid_d = cap_op2_valid;
            op2_type_d  = bus.in_op2_type;
            phys_rd_d   = bus.in_phys_rd;
        end else if (fire) begin
            out_v_d = '0;
        end
    end

    // Busy table. Writeback clears come first, so that a new destination
    // allocated in the same cycle for the same tag stays busy.
    always_comb begin
        busy_d = busy_q;
        for (int b = 0; b < DISPATCH_WIDTH; b++)
            if (bus.wb_valid[b]) busy_d[bus.wb_phys_rd[b]] = 1'b0;
        if (accept)
            for (int i = 0; i < DISPATCH_WIDTH; i++)
                if (bus.in_valid[i] && bus.in_rd_en[i] && bus.in_phys_rd[i] != '0)
                    busy_d[bus.in_phys_rd[i]] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            out_v_q <= '0;
        end else begin
            busy_q  <= busy_d;
            out_v_q <= out_v_d;
        end
    end

    // The payload has no reset. Nothing reads it unless out_v_q is set.
    always_ff @(posedge clk) begin
        alu_cmd_q   <= alu_cmd_d;
        op1_q       <= op1_d;
        op1_valid_q <= op1_valid_d;
        op2_q       <= op2_d;
        op2_valid_q <= op2_valid_d;
        op2_type_q  <= op2_type_d;
        phys_rd_q   <= phys_rd_d;
    end

    assign bus.isq_en        = out_v_q & {2{fire && !rst}};
    assign bus.isq_alu_cmd   = alu_cmd_q;
    assign bus.isq_op1       = op1_q;
    assign bus.isq_op1_valid = op1_valid_q;
    assign bus.isq_op2       = op2_q;
    assign bus.isq_op2_valid = op2_valid_q;
    assign bus.isq_op2_type  = op2_type_q;
    assign bus.isq_phys_rd   = phys_rd_q;
endmodule
